red_blob_tracker: RTL
=====================

RED_BLOB_TRACKER -- requirements
Module: red_blob_tracker

Interface
REQ-001 SHALL have parameter IMG_W, default 640, meaning pixels per line.
REQ-002 SHALL have parameter IMG_H, default 480, meaning lines per frame.
REQ-003 SHALL have parameter R_MIN, default 4'hC, meaning minimum red nibble for a red pixel.
REQ-004 SHALL have parameter GB_MAX, default 4'h4, meaning maximum green and blue nibble for a red pixel.
REQ-005 SHALL have parameter MIN_PIXELS, default 16, meaning minimum red count for o_found.
REQ-006 SHALL have port i_clk  input  1  sole clock; one clock, all logic on rising edge.
REQ-007 SHALL have port i_rst  input  1  reset, asynchronous, active-high.
REQ-008 SHALL have port i_flush  input  1  synchronous frame resync.
REQ-009 SHALL have port i_obuf_data  input  12  RGB444 pixel {R[11:8],G[7:4],B[3:0]}, first-word-fall-through.
REQ-010 SHALL have port i_obuf_empty  input  1  upstream output buffer empty.
REQ-011 SHALL have port o_obuf_rd  output  1  pop strobe to upstream buffer.
REQ-012 SHALL have ports o_min_x, o_max_x  output  10  bounding-box columns; o_min_y, o_max_y  output  9  bounding-box rows.
REQ-013 SHALL have port o_count  output  19  red pixels in last completed frame.
REQ-014 SHALL have port o_found  output  1  o_count >= MIN_PIXELS.
REQ-015 SHALL have ports o_cx  output  10, o_cy  output  9  centroid (zero when CENTROID_EN absent).
REQ-016 SHALL have port o_result_valid  output  1  one-cycle pulse, all result outputs updated.
REQ-017 SHALL have port o_overrun  output  1  sticky: frame ended while centroid divide busy.

Function
REQ-018 o_obuf_rd SHALL equal !i_obuf_empty && !i_flush combinationally; a pixel is consumed on each edge where o_obuf_rd=1.
REQ-019 Pixel red test SHALL be R>=R_MIN && G<=GB_MAX && B<=GB_MAX.
REQ-020 Column counter x SHALL advance per consumed pixel, wrap IMG_W-1->0 and increment row y; y SHALL wrap IMG_H-1->0 at frame end.
REQ-021 Per frame SHALL track min/max x, min/max y, and 19-bit red count; first red pixel initialises all four extremes.
REQ-022 Consuming pixel (IMG_W-1,IMG_H-1) SHALL snapshot accumulators to result registers and clear accumulators so the next pixel starts a fresh frame with no lost cycle.
REQ-023 When snapshot count==0, o_min_x/o_max_x/o_min_y/o_max_y/o_cx/o_cy SHALL be 0 and o_found 0.
REQ-024 Without CENTROID_EN, o_result_valid SHALL pulse in the cycle immediately after the last-pixel pop.
REQ-025 Gaps (i_obuf_empty=1) SHALL freeze x, y and accumulators; results identical to gapless stream.
REQ-026 i_flush=1 SHALL on next edge zero x, y, accumulators, abort any divide, and suppress o_result_valid; result registers keep prior values.
REQ-027 Result outputs SHALL hold until next o_result_valid.

Reset
REQ-028 i_rst=1 SHALL asynchronously clear x, y, accumulators, all result outputs, o_result_valid, o_overrun, divider state.
REQ-029 Reset mid-frame SHALL discard partial frame; first pixel after deassertion is (0,0).

Configuration
REQ-030 Macro RED_BLOB_CENTROID_EN SHALL, when defined, add 28-bit sum_x and sum_y accumulators and one shared restoring divider (FSM IDLE->DIV_X->DIV_Y->IDLE, one quotient bit per cycle, 28 cycles each).
REQ-031 With RED_BLOB_CENTROID_EN, o_cx=sum_x/count, o_cy=sum_y/count truncated; o_result_valid SHALL pulse 57 cycles after last-pixel pop; frame end while not IDLE SHALL restart divide on new snapshot and set o_overrun.
REQ-032 Without RED_BLOB_CENTROID_EN, no sum or divider logic SHALL exist; o_cx=o_cy=0, o_overrun=0.

Verification
REQ-033 640x480 frame, 12'hF00 box x160..480 y120..360, rest 000 -> min_x=160 max_x=480 min_y=120 max_y=360 count=77361 found=1 (cx=320 cy=240 with macro).
REQ-034 All-black frame -> count=0, found=0, all bbox/centroid outputs 0, valid pulses once.
REQ-035 Single 12'hF00 at (639,479), empty toggled every other cycle -> bbox 639/639/479/479, count=1, found=0, valid timing per REQ-024/031 from last pop.
REQ-036 i_flush at pixel 1000 of frame with box, then full box frame -> no valid from aborted frame, next results match REQ-033.
REQ-037 i_rst pulsed mid-frame -> all outputs 0 immediately; following full frame yields REQ-033 values.
REQ-038 Pixel 12'hB00 and 12'hC50 inside box -> not counted (R<C, G>4).

Source files
------------

// File: rtl/red_blob_tracker.sv
// Red blob tracker: classifies an RGB444 pixel stream and reports bounding box and red-pixel count per frame.
// Define RED_BLOB_CENTROID_EN to add centroid sums and a shared restoring divider for o_cx/o_cy.
module red_blob_tracker #(
  parameter int         IMG_W      = 640,
  parameter int         IMG_H      = 480,
  parameter logic [3:0] R_MIN      = 4'hC,
  parameter logic [3:0] GB_MAX     = 4'h4,
  parameter int         MIN_PIXELS = 16
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_flush,
  input  logic [11:0] i_obuf_data,
  input  logic        i_obuf_empty,
  output logic        o_obuf_rd,
  output logic [9:0]  o_min_x,
  output logic [9:0]  o_max_x,
  output logic [8:0]  o_min_y,
  output logic [8:0]  o_max_y,
  output logic [18:0] o_count,
  output logic        o_found,
  output logic [9:0]  o_cx,
  output logic [8:0]  o_cy,
  output logic        o_result_valid,
  output logic        o_overrun
);

  localparam logic [9:0]  LP_X_LAST = 10'(IMG_W - 1);
  localparam logic [8:0]  LP_Y_LAST = 9'(IMG_H - 1);
  localparam logic [18:0] LP_MIN    = 19'(MIN_PIXELS);

  function automatic logic f_found(input logic [18:0] cnt);
    return (cnt != '0) && (cnt >= LP_MIN);
  endfunction

  logic [9:0]  r_x;
  logic [8:0]  r_y;
  logic [9:0]  r_acc_min_x, r_acc_max_x;
  logic [8:0]  r_acc_min_y, r_acc_max_y;
  logic [18:0] r_acc_cnt;
  logic [9:0]  r_min_x, r_max_x, r_cx;
  logic [8:0]  r_min_y, r_max_y, r_cy;
  logic [18:0] r_count;
  logic        r_found, r_valid, r_overrun;

  logic        w_pop, w_red, w_hit, w_first, w_last_pop;
  logic [9:0]  w_nxt_min_x, w_nxt_max_x;
  logic [8:0]  w_nxt_min_y, w_nxt_max_y;
  logic [18:0] w_nxt_cnt;

  assign w_pop      = !i_obuf_empty && !i_flush;
  assign o_obuf_rd  = w_pop;
  assign w_red      = (i_obuf_data[11:8] >= R_MIN) && (i_obuf_data[7:4] <= GB_MAX) &&
                      (i_obuf_data[3:0] <= GB_MAX);
  assign w_hit      = w_pop && w_red;
  assign w_first    = (r_acc_cnt == '0);
  assign w_last_pop = w_pop && (r_x == LP_X_LAST) && (r_y == LP_Y_LAST);

  // Accumulator values including the pixel being consumed this cycle
  always_comb begin
    w_nxt_min_x = r_acc_min_x;
    w_nxt_max_x = r_acc_max_x;
    w_nxt_min_y = r_acc_min_y;
    w_nxt_max_y = r_acc_max_y;
    w_nxt_cnt   = r_acc_cnt;
    if (w_hit) begin
      if (w_first || r_x < r_acc_min_x) w_nxt_min_x = r_x;
      if (w_first || r_x > r_acc_max_x) w_nxt_max_x = r_x;
      if (w_first || r_y < r_acc_min_y) w_nxt_min_y = r_y;
      if (w_first || r_y > r_acc_max_y) w_nxt_max_y = r_y;
      w_nxt_cnt = r_acc_cnt + 19'd1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_x <= '0;
      r_y <= '0;
    end else if (i_flush) begin
      r_x <= '0;
      r_y <= '0;
    end else if (w_pop) begin
      if (r_x == LP_X_LAST) begin
        r_x <= '0;
        r_y <= (r_y == LP_Y_LAST) ? 9'd0 : r_y + 9'd1;
      end else begin
        r_x <= r_x + 10'd1;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_acc_min_x <= '0;
      r_acc_max_x <= '0;
      r_acc_min_y <= '0;
      r_acc_max_y <= '0;
      r_acc_cnt   <= '0;
    end else if (i_flush || w_last_pop) begin
      r_acc_min_x <= '0;
      r_acc_max_x <= '0;
      r_acc_min_y <= '0;
      r_acc_max_y <= '0;
      r_acc_cnt   <= '0;
    end else if (w_pop) begin
      r_acc_min_x <= w_nxt_min_x;
      r_acc_max_x <= w_nxt_max_x;
      r_acc_min_y <= w_nxt_min_y;
      r_acc_max_y <= w_nxt_max_y;
      r_acc_cnt   <= w_nxt_cnt;
    end
  end

`ifdef RED_BLOB_CENTROID_EN
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DIV_X = 2'd1;
  localparam logic [1:0] S_DIV_Y = 2'd2;

  logic [27:0] r_acc_sum_x, r_acc_sum_y, w_nxt_sum_x, w_nxt_sum_y;
  logic [1:0]  r_state;
  logic [4:0]  r_step;
  logic [27:0] r_dq, r_sy;
  logic [18:0] r_rem, w_rem_nxt;
  logic [9:0]  r_qx;
  logic [9:0]  r_snap_min_x, r_snap_max_x;
  logic [8:0]  r_snap_min_y, r_snap_max_y;
  logic [18:0] r_snap_cnt;
  logic [19:0] w_shift, w_diff;
  logic [27:0] w_dq_nxt;
  logic        w_ge;

  assign w_nxt_sum_x = r_acc_sum_x + (w_hit ? 28'(r_x) : 28'd0);
  assign w_nxt_sum_y = r_acc_sum_y + (w_hit ? 28'(r_y) : 28'd0);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_acc_sum_x <= '0;
      r_acc_sum_y <= '0;
    end else if (i_flush || w_last_pop) begin
      r_acc_sum_x <= '0;
      r_acc_sum_y <= '0;
    end else if (w_pop) begin
      r_acc_sum_x <= w_nxt_sum_x;
      r_acc_sum_y <= w_nxt_sum_y;
    end
  end

  // One restoring step: dividend shifts out of r_dq while quotient bits shift in
  assign w_shift   = {r_rem, r_dq[27]};
  assign w_diff    = w_shift - {1'b0, r_snap_cnt};
  assign w_ge      = (w_shift >= {1'b0, r_snap_cnt});
  assign w_rem_nxt = w_ge ? w_diff[18:0] : w_shift[18:0];
  assign w_dq_nxt  = {r_dq[26:0], w_ge};

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;  r_step <= '0;  r_dq <= '0;  r_sy <= '0;
      r_rem <= '0;  r_qx <= '0;  r_snap_cnt <= '0;
      r_snap_min_x <= '0;  r_snap_max_x <= '0;
      r_snap_min_y <= '0;  r_snap_max_y <= '0;
      r_min_x <= '0;  r_max_x <= '0;  r_min_y <= '0;  r_max_y <= '0;
      r_count <= '0;  r_found <= 1'b0;  r_cx <= '0;  r_cy <= '0;
      r_valid <= 1'b0;  r_overrun <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (i_flush) begin
        r_state <= S_IDLE;
      end else if (w_last_pop) begin
        if (r_state != S_IDLE) r_overrun <= 1'b1;
        r_snap_min_x <= w_nxt_min_x;
        r_snap_max_x <= w_nxt_max_x;
        r_snap_min_y <= w_nxt_min_y;
        r_snap_max_y <= w_nxt_max_y;
        r_snap_cnt   <= w_nxt_cnt;
        r_dq    <= w_nxt_sum_x;
        r_sy    <= w_nxt_sum_y;
        r_rem   <= '0;
        r_step  <= '0;
        r_state <= S_DIV_X;
      end else begin
        case (r_state)
          S_DIV_X: begin
            r_rem  <= w_rem_nxt;
            r_dq   <= w_dq_nxt;
            r_step <= r_step + 5'd1;
            if (r_step == 5'd27) begin
              r_qx    <= w_dq_nxt[9:0];
              r_dq    <= r_sy;
              r_rem   <= '0;
              r_step  <= '0;
              r_state <= S_DIV_Y;
            end
          end
          S_DIV_Y: begin
            r_rem  <= w_rem_nxt;
            r_dq   <= w_dq_nxt;
            r_step <= r_step + 5'd1;
            if (r_step == 5'd27) begin
              r_min_x <= r_snap_min_x;
              r_max_x <= r_snap_max_x;
              r_min_y <= r_snap_min_y;
              r_max_y <= r_snap_max_y;
              r_count <= r_snap_cnt;
              r_found <= f_found(r_snap_cnt);
              r_cx    <= (r_snap_cnt == '0) ? 10'd0 : r_qx;
              r_cy    <= (r_snap_cnt == '0) ? 9'd0 : w_dq_nxt[8:0];
              r_valid <= 1'b1;
              r_state <= S_IDLE;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end
`else
  assign r_cx      = '0;
  assign r_cy      = '0;
  assign r_overrun = 1'b0;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_min_x <= '0;  r_max_x <= '0;  r_min_y <= '0;  r_max_y <= '0;
      r_count <= '0;  r_found <= 1'b0;  r_valid <= 1'b0;
    end else begin
      r_valid <= w_last_pop;
      if (w_last_pop) begin
        r_min_x <= w_nxt_min_x;
        r_max_x <= w_nxt_max_x;
        r_min_y <= w_nxt_min_y;
        r_max_y <= w_nxt_max_y;
        r_count <= w_nxt_cnt;
        r_found <= f_found(w_nxt_cnt);
      end
    end
  end
`endif

  assign o_min_x        = r_min_x;
  assign o_max_x        = r_max_x;
  assign o_min_y        = r_min_y;
  assign o_max_y        = r_max_y;
  assign o_count        = r_count;
  assign o_found        = r_found;
  assign o_cx           = r_cx;
  assign o_cy           = r_cy;
  assign o_result_valid = r_valid;
  assign o_overrun      = r_overrun;

endmodule
